// File: rtl/hazard_fwd_unit.sv
// Pipeline hazard / forwarding control: operand bypass selects, load-use stall, branch flush, memory-wait freeze.
// Latency: forwarding and pipeline controls are combinational from the current inputs; err/stall_cnt update on the clock edge.
// Backpressure: mem_busy freezes the whole pipe (pipe_hold) and, after TIMEOUT busy cycles, locks into ERROR until reset.
module hazard_fwd_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  id_rn,
    input  logic [3:0]  id_rm,
    input  logic [3:0]  id_rd,
    input  logic        id_use_rn,
    input  logic        id_use_rm,
    input  logic        id_use_rd,
    input  logic        branch_taken,
    input  logic [3:0]  ex_rd,
    input  logic        ex_rf,
    input  logic        ex_load,
    input  logic [3:0]  mem_rd,
    input  logic        mem_rf,
    input  logic [3:0]  wb_rd,
    input  logic        wb_rf,
    input  logic        mem_busy,
    output logic        nop_sel,
    output logic        pc_ld,
    output logic        ifid_ld,
    output logic        ifid_clr,
    output logic        pipe_hold,
    output logic [1:0]  fwd_rn,
    output logic [1:0]  fwd_rm,
    output logic [1:0]  fwd_rd,
    output logic        err,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    localparam logic [1:0] SRC_RF  = 2'b00;
    localparam logic [1:0] SRC_EX  = 2'b01;
    localparam logic [1:0] SRC_MEM = 2'b10;
    localparam logic [1:0] SRC_WB  = 2'b11;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_nxt;
    logic [7:0] wait_inc;
    logic       err_nxt;
    logic       lu;

    // Youngest producer wins; a load in EX has no data yet so it never bypasses.
    // r15 (the PC) is always read from the register file.
    function automatic logic [1:0] fwd_pick(
        input logic [3:0] src,
        input logic       src_used,
        input logic [3:0] e_rd,
        input logic       e_rf,
        input logic       e_load,
        input logic [3:0] m_rd,
        input logic       m_rf,
        input logic [3:0] w_rd,
        input logic       w_rf
    );
        logic [1:0] sel;
        sel = SRC_RF;
        if (src_used && (src != 4'hF)) begin
            if (e_rf && !e_load && (e_rd == src)) begin
                sel = SRC_EX;
            end else if (m_rf && (m_rd == src)) begin
                sel = SRC_MEM;
            end else if (w_rf && (w_rd == src)) begin
                sel = SRC_WB;
            end
        end
        return sel;
    endfunction

    // Operand bypass selects for the three ID-stage sources.
    always_comb begin
        fwd_rn = fwd_pick(id_rn, id_use_rn, ex_rd, ex_rf, ex_load, mem_rd, mem_rf, wb_rd, wb_rf);
        fwd_rm = fwd_pick(id_rm, id_use_rm, ex_rd, ex_rf, ex_load, mem_rd, mem_rf, wb_rd, wb_rf);
        fwd_rd = fwd_pick(id_rd, id_use_rd, ex_rd, ex_rf, ex_load, mem_rd, mem_rf, wb_rd, wb_rf);
    end

    // Load-use: a load in EX writing a register that ID is about to read.
    always_comb begin
        lu = ex_load && ex_rf && (ex_rd != 4'hF) &&
             ((id_use_rn && (id_rn == ex_rd)) ||
              (id_use_rm && (id_rm == ex_rd)) ||
              (id_use_rd && (id_rd == ex_rd)));
    end

    // Next state and pipeline controls; priority is mem_busy > load-use > branch.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        err_nxt      = err;
        wait_inc     = wait_cnt + 8'd1;
        nop_sel      = 1'b0;
        pc_ld        = 1'b1;
        ifid_ld      = 1'b1;
        ifid_clr     = 1'b0;
        pipe_hold    = 1'b0;
        case (state)
            RUN, MEM_WAIT: begin
                if (mem_busy) begin
                    // Freeze everything; wait_cnt counts consecutive busy cycles.
                    pipe_hold    = 1'b1;
                    pc_ld        = 1'b0;
                    ifid_ld      = 1'b0;
                    wait_cnt_nxt = wait_inc;
                    if (wait_inc >= TIMEOUT_CNT) begin
                        state_nxt = ERROR;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt = MEM_WAIT;
                    end
                end else begin
                    // Memory ready: RUN rules apply in this very cycle.
                    state_nxt    = RUN;
                    wait_cnt_nxt = 8'd0;
                    if (lu) begin
                        // One-cycle bubble; the branch (if any) is re-presented next cycle.
                        nop_sel = 1'b1;
                        pc_ld   = 1'b0;
                        ifid_ld = 1'b0;
                    end else if (branch_taken) begin
                        ifid_clr = 1'b1;
                    end
                end
            end
            ERROR: begin
                nop_sel   = 1'b1;
                pc_ld     = 1'b0;
                ifid_ld   = 1'b0;
                pipe_hold = 1'b1;
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = 8'd0;
            end
        endcase
    end

    // FSM state, wait counter and sticky error flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            err      <= err_nxt;
        end
    end

    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= 16'd0;
        end else if (!pc_ld && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed-vector bench for hazard_fwd_unit with a queue-based scoreboard.
// Latency: driver applies a vector 1 time unit after posedge; monitor compares at the following negedge.
// Backpressure: none; every queued expectation is consumed at the next negedge.
module tb_hazard_fwd_unit;

    localparam logic [3:0] K_NOP  = 4'd0;
    localparam logic [3:0] K_PCLD = 4'd1;
    localparam logic [3:0] K_IFLD = 4'd2;
    localparam logic [3:0] K_CLR  = 4'd3;
    localparam logic [3:0] K_HOLD = 4'd4;
    localparam logic [3:0] K_FRN  = 4'd5;
    localparam logic [3:0] K_FRM  = 4'd6;
    localparam logic [3:0] K_FRD  = 4'd7;
    localparam logic [3:0] K_ERR  = 4'd8;
    localparam logic [3:0] K_SCNT = 4'd9;

    typedef struct packed {
        logic [3:0]  kind;
        logic [15:0] val;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic [3:0]  id_rn, id_rm, id_rd;
    logic        id_use_rn, id_use_rm, id_use_rd;
    logic        branch_taken;
    logic [3:0]  ex_rd;
    logic        ex_rf, ex_load;
    logic [3:0]  mem_rd;
    logic        mem_rf;
    logic [3:0]  wb_rd;
    logic        wb_rf;
    logic        mem_busy;
    logic        nop_sel, pc_ld, ifid_ld, ifid_clr, pipe_hold;
    logic [1:0]  fwd_rn, fwd_rm, fwd_rd;
    logic        err;
    logic [15:0] stall_cnt;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    exp_t        mon_e;
    string       mon_nm;
    logic [15:0] mon_act;

    hazard_fwd_unit #(.TIMEOUT(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .id_rn        (id_rn),
        .id_rm        (id_rm),
        .id_rd        (id_rd),
        .id_use_rn    (id_use_rn),
        .id_use_rm    (id_use_rm),
        .id_use_rd    (id_use_rd),
        .branch_taken (branch_taken),
        .ex_rd        (ex_rd),
        .ex_rf        (ex_rf),
        .ex_load      (ex_load),
        .mem_rd       (mem_rd),
        .mem_rf       (mem_rf),
        .wb_rd        (wb_rd),
        .wb_rf        (wb_rf),
        .mem_busy     (mem_busy),
        .nop_sel      (nop_sel),
        .pc_ld        (pc_ld),
        .ifid_ld      (ifid_ld),
        .ifid_clr     (ifid_clr),
        .pipe_hold    (pipe_hold),
        .fwd_rn       (fwd_rn),
        .fwd_rm       (fwd_rm),
        .fwd_rd       (fwd_rd),
        .err          (err),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare every queued expectation against the live outputs.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_e  = exp_q.pop_front();
            mon_nm = name_q.pop_front();
            case (mon_e.kind)
                K_NOP:   mon_act = {15'd0, nop_sel};
                K_PCLD:  mon_act = {15'd0, pc_ld};
                K_IFLD:  mon_act = {15'd0, ifid_ld};
                K_CLR:   mon_act = {15'd0, ifid_clr};
                K_HOLD:  mon_act = {15'd0, pipe_hold};
                K_FRN:   mon_act = {14'd0, fwd_rn};
                K_FRM:   mon_act = {14'd0, fwd_rm};
                K_FRD:   mon_act = {14'd0, fwd_rd};
                K_ERR:   mon_act = {15'd0, err};
                K_SCNT:  mon_act = stall_cnt;
                default: mon_act = 16'hDEAD;
            endcase
            checks++;
            if (mon_act !== mon_e.val) begin
                errors++;
                $display("FAIL %s: got %0h expected %0h", mon_nm, mon_act, mon_e.val);
            end
        end
    end

    task automatic exp_push(input logic [3:0] kind, input logic [15:0] val, input string nm);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Expected pipeline controls for one cycle.
    task automatic exp_ctl(input string tag, input logic nop, input logic pcl, input logic ifl,
                           input logic clr, input logic hold);
        exp_push(K_NOP,  {15'd0, nop},  {tag, ".nop_sel"});
        exp_push(K_PCLD, {15'd0, pcl},  {tag, ".pc_ld"});
        exp_push(K_IFLD, {15'd0, ifl},  {tag, ".ifid_ld"});
        exp_push(K_CLR,  {15'd0, clr},  {tag, ".ifid_clr"});
        exp_push(K_HOLD, {15'd0, hold}, {tag, ".pipe_hold"});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        id_rn = 4'd0; id_rm = 4'd0; id_rd = 4'd0;
        id_use_rn = 1'b0; id_use_rm = 1'b0; id_use_rd = 1'b0;
        branch_taken = 1'b0;
        ex_rd = 4'd0; ex_rf = 1'b0; ex_load = 1'b0;
        mem_rd = 4'd0; mem_rf = 1'b0;
        wb_rd = 4'd0; wb_rf = 1'b0;
        mem_busy = 1'b0;
    endtask

    task automatic set_lu();
        ex_load = 1'b1; ex_rf = 1'b1; ex_rd = 4'd3;
        id_rn = 4'd3; id_use_rn = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        clr_inputs();
        step();
        // Reset values and RUN-rule outputs during reset.
        exp_ctl("rst", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        exp_push(K_ERR,  16'd0, "rst.err");
        exp_push(K_SCNT, 16'd0, "rst.stall_cnt");
        step();
        reset_n = 1'b1;
        exp_push(K_SCNT, 16'd0, "rel.stall_cnt");
        step();

        // Load-use: one bubble cycle, then release once EX holds the bubble.
        set_lu();
        exp_ctl("lu", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_push(K_FRN,  16'd0, "lu.fwd_rn");
        exp_push(K_SCNT, 16'd0, "lu.stall_cnt");
        step();
        clr_inputs();
        id_rn = 4'd3; id_use_rn = 1'b1;
        exp_ctl("lu_rel", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        exp_push(K_SCNT, 16'd1, "lu_rel.stall_cnt");
        step();

        // Forwarding priority EX > MEM > WB, r15 and unused sources stay on RF.
        clr_inputs();
        ex_rf = 1'b1; ex_rd = 4'd5;
        mem_rf = 1'b1; mem_rd = 4'd5;
        id_rm = 4'd5; id_use_rm = 1'b1;
        id_rd = 4'd5; id_use_rd = 1'b0;
        exp_push(K_FRM, 16'd1, "fwd_ex.fwd_rm");
        exp_push(K_FRD, 16'd0, "fwd_unused.fwd_rd");
        exp_push(K_FRN, 16'd0, "fwd_unused.fwd_rn");
        step();
        ex_rf = 1'b0;
        wb_rf = 1'b1; wb_rd = 4'd15;
        id_rn = 4'd15; id_use_rn = 1'b1;
        id_use_rd = 1'b1;
        exp_push(K_FRM, 16'd2, "fwd_mem.fwd_rm");
        exp_push(K_FRD, 16'd2, "fwd_mem.fwd_rd");
        exp_push(K_FRN, 16'd0, "fwd_r15.fwd_rn");
        step();
        mem_rf = 1'b0; wb_rd = 4'd5;
        ex_load = 1'b1; ex_rf = 1'b1; ex_rd = 4'd15;
        exp_push(K_FRM,  16'd3, "fwd_wb.fwd_rm");
        exp_push(K_PCLD, 16'd1, "lu_r15.pc_ld");
        exp_push(K_NOP,  16'd0, "lu_r15.nop_sel");
        step();

        // Branch together with load-use: stall wins, flush follows.
        clr_inputs();
        set_lu();
        branch_taken = 1'b1;
        exp_ctl("br_lu", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_push(K_SCNT, 16'd1, "br_lu.stall_cnt");
        step();
        ex_load = 1'b0; ex_rf = 1'b0;
        exp_push(K_CLR,  16'd1, "br.ifid_clr");
        exp_push(K_PCLD, 16'd1, "br.pc_ld");
        exp_push(K_NOP,  16'd0, "br.nop_sel");
        exp_push(K_SCNT, 16'd2, "br.stall_cnt");
        step();

        // mem_busy for 4 cycles (first one also carries a load-use hazard).
        clr_inputs();
        for (int i = 0; i < 4; i++) begin
            mem_busy = 1'b1;
            if (i == 0) set_lu();
            else begin
                ex_load = 1'b0; ex_rf = 1'b0;
            end
            exp_ctl($sformatf("busy%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            exp_push(K_SCNT, 16'(2 + i), $sformatf("busy%0d.stall_cnt", i));
            step();
        end
        clr_inputs();
        exp_ctl("busy_end", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        exp_push(K_SCNT, 16'd6, "busy_end.stall_cnt");
        exp_push(K_ERR,  16'd0, "busy_end.err");
        step();

        // Timeout: 8 busy cycles enter ERROR; err is sticky until reset.
        for (int i = 1; i <= 8; i++) begin
            mem_busy = 1'b1;
            if (i == 4 || i == 8) begin
                exp_push(K_ERR,  16'd0, $sformatf("to%0d.err", i));
                exp_push(K_HOLD, 16'd1, $sformatf("to%0d.pipe_hold", i));
                exp_push(K_NOP,  16'd0, $sformatf("to%0d.nop_sel", i));
            end
            step();
        end
        exp_ctl("error", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_push(K_ERR,  16'd1, "error.err");
        exp_push(K_SCNT, 16'd14, "error.stall_cnt");
        step();
        mem_busy = 1'b0;
        exp_ctl("err_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_push(K_ERR,  16'd1, "err_idle.err");
        exp_push(K_SCNT, 16'd15, "err_idle.stall_cnt");
        step();
        reset_n = 1'b0;
        exp_push(K_ERR,  16'd0, "err_rst.err");
        exp_push(K_SCNT, 16'd0, "err_rst.stall_cnt");
        exp_push(K_PCLD, 16'd1, "err_rst.pc_ld");
        step();
        reset_n = 1'b1;
        exp_ctl("err_rel", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        exp_push(K_ERR, 16'd0, "err_rel.err");
        step();

        // Reset taken while in MEM_WAIT leaves no hold behind.
        mem_busy = 1'b1;
        step();
        step();
        mem_busy = 1'b0;
        reset_n  = 1'b0;
        exp_push(K_HOLD, 16'd0, "mw_rst.pipe_hold");
        exp_push(K_SCNT, 16'd0, "mw_rst.stall_cnt");
        step();
        reset_n = 1'b1;
        exp_ctl("mw_rel", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step();

        // Continuous load-use stall saturates the counter.
        set_lu();
        for (int i = 0; i < 70000; i++) step();
        exp_push(K_SCNT, 16'hFFFF, "sat.stall_cnt");
        exp_push(K_PCLD, 16'd0, "sat.pc_ld");
        step();
        exp_push(K_SCNT, 16'hFFFF, "sat_hold.stall_cnt");
        step();
        clr_inputs();
        step();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_unit.md
HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 The block SHALL have the parameter TIMEOUT, default 255, meaning the number of consecutive mem_busy cycles before the ERROR state is entered (range 1..255).
REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- id_rn, id_rm, id_rd  in  4 each  ID-stage source register numbers (rd is the store-data source)
- id_use_rn, id_use_rm, id_use_rd  in  1 each  the corresponding ID source is read
- branch_taken  in  1  ID-stage branch resolves taken
- ex_rd  in  4  EX destination register
- ex_rf  in  1  EX RF write enable
- ex_load  in  1  EX is a load
- mem_rd  in  4  MEM destination register
- mem_rf  in  1  MEM RF write enable
- wb_rd  in  4  WB destination register
- wb_rf  in  1  WB RF write enable
- mem_busy  in  1  data memory not ready
- nop_sel  out  1  select of the control-unit NOP mux (1 = zero all control signals into ID/EX)
- pc_ld  out  1  PC load enable
- ifid_ld  out  1  IF/ID load enable
- ifid_clr  out  1  IF/ID synchronous clear (flush)
- pipe_hold  out  1  freezes ID/EX, EX/MEM and MEM/WB
- fwd_rn, fwd_rm, fwd_rd  out  2 each  operand source: 00 RF, 01 EX, 10 MEM, 11 WB
- err  out  1  sticky memory-timeout flag
- stall_cnt  out  16  saturating count of stall cycles

Function
REQ-003 Forwarding SHALL be combinational; for each source s: EX is selected if ex_rf and !ex_load and ex_rd==s; else MEM if mem_rf and mem_rd==s; else WB if wb_rf and wb_rd==s; else 00.
REQ-004 Register 15 SHALL never be forwarded (fwd = 00 whenever the source is 4'hF).
REQ-005 An unused source (id_use_x=0) SHALL have fwd_x = 00.
REQ-006 A load-use hazard (lu) SHALL be ex_load and ex_rf and ex_rd != 15 and ex_rd equal to any used ID source.
REQ-007 The FSM SHALL have the states RUN, MEM_WAIT and ERROR, held in registers.
REQ-008 In RUN with mem_busy=0 and lu=1, the outputs SHALL be nop_sel=1, pc_ld=0, ifid_ld=0 and ifid_clr=0 for exactly that cycle; the stall releases automatically once EX holds the bubble.
REQ-009 In RUN with mem_busy=0, lu=0 and branch_taken=1, the outputs SHALL be ifid_clr=1 and pc_ld=1.
REQ-010 In RUN with none of the above, the outputs SHALL be pc_ld=1, ifid_ld=1 and all other controls 0.
REQ-011 Priority SHALL be mem_busy > lu > branch_taken; a branch coincident with lu is ignored that cycle and re-presented after the stall.
REQ-012 When mem_busy=1 in RUN, the FSM SHALL go to MEM_WAIT; in the same cycle pipe_hold=1, pc_ld=0, ifid_ld=0, nop_sel=0 and ifid_clr=0.
REQ-013 In MEM_WAIT the outputs SHALL be the same as in REQ-012 while mem_busy=1; an 8-bit wait counter increments each cycle.
REQ-014 When mem_busy=0 in MEM_WAIT, the FSM SHALL return to RUN, clear the wait counter, and apply the RUN rules combinationally that cycle.
REQ-015 When the wait counter reaches TIMEOUT with mem_busy still 1, the FSM SHALL go to ERROR and set err=1.
REQ-016 ERROR SHALL be terminal until reset, with pc_ld=0, ifid_ld=0, pipe_hold=1 and nop_sel=1.
REQ-017 stall_cnt SHALL increment by 1 on every clock where pc_ld=0, and saturate at 16'hFFFF.

Reset
REQ-018 While reset_n=0, the block SHALL asynchronously set: state=RUN, wait counter=0, err=0, stall_cnt=0.
REQ-019 During reset, the combinational outputs SHALL follow the RUN rules from the current inputs.
REQ-020 Reset asserted in MEM_WAIT or ERROR SHALL return the block to RUN with no residual hold on the first clock after release.

Verification
REQ-021 The bench SHALL cover these scenarios:
- ex_load=1, ex_rf=1, ex_rd=3, id_rn=3, id_use_rn=1 -> one cycle nop_sel=1, pc_ld=0, ifid_ld=0; stall_cnt 0->1.
- ex_rf=1, ex_rd=5, !ex_load; mem_rf=1, mem_rd=5; id_rm=5 used -> fwd_rm=01; then ex_rf=0 -> fwd_rm=10; id_rn=15 with wb_rd=15 -> fwd_rn=00.
- branch_taken=1 together with lu=1 -> cycle 1 stall only (ifid_clr=0); cycle 2 with lu=0 -> ifid_clr=1, pc_ld=1.
- mem_busy high for 4 cycles -> pipe_hold=1 for 4 cycles, state back to RUN on the 5th, stall_cnt +4, err=0.
- TIMEOUT=8, mem_busy held -> err=1 after 8 wait cycles; mem_busy drop does not clear it; reset_n pulse -> err=0, state RUN.
- 70000 consecutive stall cycles -> stall_cnt holds at 16'hFFFF.
